imem_loader: RTL

Program loader that fills the instruction memory through its write port before the core runs. It accepts a little-endian byte stream over a valid/ready handshake and packs every 4 bytes into a 32-bit instruction. Each word is written through the `WriteReg`/`WriteData`/`RegWrite` port at consecutive word addresses. The core is held via `cpu_hold` until the programmed word count has been written.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic logic [WORD_W-1:0] wrap_add(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects little-endian bytes into a 32-bit word; word_next includes the byte
// being accepted this cycle so the caller can latch a complete word immediately.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        in_byte,
  output logic              word_full,
  output logic [WORD_W-1:0] word_next
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  // next byte index and assembly contents
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = 2'd0;
      word_d = {WORD_W{1'b0}};
    end else if (accept) begin
      word_d[{idx_q, 3'b000} +: 8] = in_byte;
      idx_d                        = idx_q + 2'd1;
    end else begin
      idx_d  = idx_q;
      word_d = word_q;
    end
    word_full = accept && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));
    word_next = word_d;
  end

  // packer state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q  <= 2'd0;
      word_q <= {WORD_W{1'b0}};
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory one word at a time, holding the core
// until the requested number of words has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'd0,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       prog_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [31:0]       WriteReg,
  output logic [31:0]       WriteData,
  output logic              RegWrite,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [31:0]       checksum
);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] RECV  = ST_RECV;
  localparam logic [2:0] WRITE = ST_WRITE;
  localparam logic [2:0] DONE  = ST_DONE;
  localparam logic [2:0] ERR   = ST_ERR;

  localparam logic [WORD_W-1:0] MAX_WORDS_W = WORD_W'(MAX_WORDS);

  logic [2:0]        state_q, state_d;
  logic [WORD_W-1:0] prog_len_q, prog_len_d;
  logic [WORD_W-1:0] count_q, count_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] checksum_q, checksum_d;
  logic              in_ready_q, in_ready_d;
  logic              regwrite_q, regwrite_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              start_ok_s;
  logic              accept_s;
  logic              word_full_s;
  logic [WORD_W-1:0] packed_word_s;

  assign start_ok_s = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign accept_s   = in_valid && in_ready_q;

  byte_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_ok_s),
    .accept    (accept_s),
    .in_byte   (in_data),
    .word_full (word_full_s),
    .word_next (packed_word_s)
  );

  // FSM next state, counters and checksum
  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    checksum_d = checksum_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_ok_s) begin
          prog_len_d = prog_len;
          count_d    = 32'd0;
          addr_d     = BASE_ADDR;
          checksum_d = 32'd0;
          if (prog_len == 32'd0) begin
            state_d = DONE;
          end else if (prog_len > MAX_WORDS_W) begin
            state_d = ERR;
          end else begin
            state_d = RECV;
          end
        end else begin
          state_d = state_q;
        end
      end
      RECV: begin
        if (word_full_s) begin
          state_d = WRITE;
          wdata_d = packed_word_s;
        end else begin
          state_d = RECV;
        end
      end
      WRITE: begin
        checksum_d = wrap_add(checksum_q, wdata_q);
        addr_d     = addr_q + 32'd1;
        count_d    = count_q + 32'd1;
        if ((count_q + 32'd1) == prog_len_q) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // outputs are registered versions of the next-state decode
    in_ready_d = (state_d == RECV);
    regwrite_d = (state_d == WRITE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    hold_d     = (state_d != DONE);
  end

  // loader state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prog_len_q <= 32'd0;
      count_q    <= 32'd0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
      checksum_q <= 32'd0;
      in_ready_q <= 1'b0;
      regwrite_q <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      checksum_q <= checksum_d;
      in_ready_q <= in_ready_d;
      regwrite_q <= regwrite_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign WriteReg  = addr_q;
  assign WriteData = wdata_q;
  assign RegWrite  = regwrite_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign checksum  = checksum_q;

endmodule
